turn_controller: RTL and testbench
==================================

# turn_controller

Turn-sequencing and aiming stage that sits directly upstream of the bomb projectile block. It turns keyboard keycodes into per-player angle/power settings, produces the `launch` pulse and launch coordinates the bomb consumes, and watches the bomb's `exploded` flag to finish the shot. After a terrain-settle delay it hands the turn to the other player.

## Interface
- `TURRET_H`, default 8: launch point height above the active tank's Y.
- `SETTLE_FRAMES`, default 30: frame ticks spent in SETTLE after impact.
- `FLIGHT_TIMEOUT`, default 600: maximum frame ticks spent in FLIGHT.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `frame_clk` in 1: vertical-sync rate signal; sampled as data, never used as a clock.
- `keycode` in 8: current USB keycode, 0x00 when no key is held.
- `tank0_x`, `tank0_y`, `tank1_x`, `tank1_y` in 10 each: tank positions.
- `exploded` in 1: bomb status; high means idle or exploded.
- `game_over` in 1: freezes aiming and firing.
- `launch` out 1: launch request to the bomb.
- `launchX`, `launchY` out 10 each: launch coordinates.
- `angle` out 4: active player's angle, 0..8.
- `power` out 3: active player's power, 0..7.
- `player` out 1: active player.
- `busy` out 1: high in any state other than AIM.
- `timeout_flag` out 1: the last shot ended by timeout.
- `turn_count` out 8: completed turns; wraps.

## Operation
- **Frame tick:** `frame_clk` passes through a 2-flop synchronizer and a rising-edge detect, giving `tick`, a 1-`clk` pulse per frame.
- **Key events:** an event is generated only when `keycode` differs from its value on the previous cycle and the new value is mapped. Held keys never repeat.
  - A (0x04): angle−1.
  - D (0x07): angle+1.
  - W (0x1A): power+1.
  - S (0x16): power−1.
  - Space (0x2C): fire.
  - Angle saturates at 0 and 8; power saturates at 0 and 7.
- **Per-player storage:** each player has its own angle and power registers. Reset values: P0 angle=6, power=4; P1 angle=2, power=4. The `angle` and `power` outputs show the active player's registers.
- **FSM, states AIM, ARM, LAUNCH, FLIGHT, SETTLE:**
  - AIM: key events are applied. A fire event with `game_over`=0 latches `launchX`=tankN_x and `launchY`=tankN_y−`TURRET_H` (mod 2^10), then goes to ARM. When `game_over`=1, all key events are ignored.
  - ARM: waits for the next `tick`; a tick in the same cycle as fire acceptance does not count. On the tick, `launch`←1 and go to LAUNCH.
  - LAUNCH: on the next `tick`, `launch`←0, clear the flight counter, go to FLIGHT.
  - FLIGHT: count ticks.
    - Require `exploded`=0 to be seen at least once; after that, `exploded`=1 → SETTLE with `timeout_flag`←0.
    - When the count reaches `FLIGHT_TIMEOUT` first → SETTLE with `timeout_flag`←1.
  - SETTLE: count `SETTLE_FRAMES` ticks, then `player` toggles, `turn_count`+1, go to AIM.
- Key events arriving outside AIM are discarded. The previous-keycode register still updates, so a key held across a turn does not fire later.
- `launchX` and `launchY` stay stable from fire acceptance until the next fire.

## Timing
- Reset (synchronous, takes effect at the next `clk` edge) sets:
  - state=AIM, `launch`=0, `launchX`=`launchY`=0, `player`=0;
  - angles and powers to the defaults above;
  - `busy`=0, `timeout_flag`=0, `turn_count`=0;
  - all counters and the synchronizer to 0.
- Reset in any state, including mid-flight, drops `launch` at that edge.
- `tick` asserts on the 3rd `clk` edge after `frame_clk` rises.
- Key event to updated `angle`/`power`: 1 cycle after `keycode` changes.
- `busy` goes high the cycle after fire is accepted.
- `launch` is high for exactly one frame period, from tick N to tick N+1. It therefore covers exactly one `frame_clk` rising edge, the one between those ticks.
- Fire and `tick` in the same cycle: the fire is accepted and the tick is ignored.
- Key event and `game_over` rising in the same cycle: the event is ignored.
- Timeout and `exploded` rising on the same tick: treated as an explosion, `timeout_flag`=0.

## Structure
- `game_pkg` holds:
  - the state enum `turn_state_t`;
  - the keycode constants `KEY_A`, `KEY_D`, `KEY_W`, `KEY_S`, `KEY_SPACE`;
  - `ANGLE_MAX`=8, `POWER_MAX`=7, and the default angle/power constants.
- Sub-module `frame_tick_sync`: synchronizer plus edge detector producing `tick`; shared with other frame-rate consumers.
- Total size ≈200 lines of RTL.

## Test plan
- **Reset defaults:** reset, then hold D for 100 cycles → angle 6→7 once only; press D twice more → angle=8 and stays 8; release and press S five times → power 4→0 and stays 0.
- **Launch framing:** tank0=(100,300), press Space → `launchX`=100, `launchY`=292, `busy`=1; `launch` rises 3 clk after the next `frame_clk` edge and falls 3 clk after the following edge.
- **Normal turn:** bomb model drops `exploded` one frame after launch and raises it 20 frames later; `SETTLE_FRAMES`=30 → `player`=1, `turn_count`=1, `angle`=2, `power`=4, `busy`=0.
- **Timeout:** `exploded` held at 1 throughout → FLIGHT exits after 600 ticks, `timeout_flag`=1, turn passes.
- **Ignored inputs:** press A during FLIGHT and Space during SETTLE → angle unchanged and no second launch; `game_over`=1 in AIM with Space pressed → no launch.
- **Reset mid-flight and wrap:** reset asserted while `launch`=1 → `launch`=0 and state=AIM on the next edge; 256 turns → `turn_count` wraps to 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: turn-sequencer states, keyboard codes and aiming limits.
package game_pkg;

  typedef enum logic [2:0] {
    ST_AIM,
    ST_ARM,
    ST_LAUNCH,
    ST_FLIGHT,
    ST_SETTLE
  } turn_state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  localparam logic [3:0] ANGLE_MAX    = 4'd8;
  localparam logic [2:0] POWER_MAX    = 3'd7;
  localparam logic [3:0] ANGLE_DEF_P0 = 4'd6;
  localparam logic [3:0] ANGLE_DEF_P1 = 4'd2;
  localparam logic [2:0] POWER_DEF    = 3'd4;

  function automatic logic key_mapped(input logic [7:0] k);
    return (k == KEY_A) || (k == KEY_D) || (k == KEY_W) ||
           (k == KEY_S) || (k == KEY_SPACE);
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the frame-rate signal into clk and emits a one-cycle pulse per rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic frame_clk,
  output logic tick
);

  logic r_sync0;
  logic r_sync1;
  logic r_sync1_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0   <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync1_d <= 1'b0;
    end else begin
      r_sync0   <= frame_clk;
      r_sync1   <= r_sync0;
      r_sync1_d <= r_sync1;
    end
  end

  // Combinational pulse so that consumers act on the third clk edge after the rise.
  assign tick = r_sync1 & ~r_sync1_d;

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: keyboard aiming per player, one-frame launch pulse, flight/settle timing.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_AIM    | active player adjusts angle/power; fire latches launch point
// ST_ARM    | fire accepted, waiting for the next frame tick
// ST_LAUNCH | launch held high for one frame
// ST_FLIGHT | bomb in the air; wait for explosion or flight timeout
// ST_SETTLE | terrain settle delay, then hand over to the other player
import game_pkg::*;

module turn_controller #(
  parameter int TURRET_H       = 8,
  parameter int SETTLE_FRAMES  = 30,
  parameter int FLIGHT_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  input  logic [9:0] tank0_x,
  input  logic [9:0] tank0_y,
  input  logic [9:0] tank1_x,
  input  logic [9:0] tank1_y,
  input  logic       exploded,
  input  logic       game_over,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic       player,
  output logic       busy,
  output logic       timeout_flag,
  output logic [7:0] turn_count
);

  localparam int CNT_MAX = (SETTLE_FRAMES > FLIGHT_TIMEOUT) ? SETTLE_FRAMES : FLIGHT_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FLIGHT_LOAD = CW'(FLIGHT_TIMEOUT - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_FRAMES - 1);

  turn_state_t r_state, w_state_next;

  logic          w_tick;
  logic [7:0]    r_key_prev;
  logic [3:0]    r_angle [2];
  logic [2:0]    r_power [2];
  logic          r_player;
  logic          r_launch;
  logic [9:0]    r_launch_x;
  logic [9:0]    r_launch_y;
  logic          r_timeout;
  logic [7:0]    r_turns;
  logic [CW-1:0] r_cnt;
  logic          r_seen_low;

  logic       w_key_apply;
  logic       w_fire;
  logic [9:0] w_tank_x;
  logic [9:0] w_tank_y;
  logic       w_set_launch;
  logic       w_clr_launch;
  logic       w_load_flight;
  logic       w_load_settle;
  logic       w_timeout;
  logic       w_dec;
  logic       w_turn_done;

  frame_tick_sync u_tick (
    .clk       (clk),
    .reset     (reset),
    .frame_clk (frame_clk),
    .tick      (w_tick)
  );

  // game_over is checked combinationally so a key arriving with its rising edge is dropped.
  assign w_key_apply = (r_state == ST_AIM) && !game_over &&
                       (keycode != r_key_prev) && key_mapped(keycode);
  assign w_fire      = w_key_apply && (keycode == KEY_SPACE);
  assign w_tank_x    = r_player ? tank1_x : tank0_x;
  assign w_tank_y    = r_player ? tank1_y : tank0_y;

  always_comb begin
    w_state_next  = r_state;
    w_set_launch  = 1'b0;
    w_clr_launch  = 1'b0;
    w_load_flight = 1'b0;
    w_load_settle = 1'b0;
    w_timeout     = 1'b0;
    w_dec         = 1'b0;
    w_turn_done   = 1'b0;
    case (r_state)
      ST_AIM: begin
        if (w_fire) w_state_next = ST_ARM;
      end
      ST_ARM: begin
        if (w_tick) begin
          w_set_launch = 1'b1;
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (w_tick) begin
          w_clr_launch  = 1'b1;
          w_load_flight = 1'b1;
          w_state_next  = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        // Explosion is tested first so it wins over a timeout on the same tick.
        if (r_seen_low && exploded) begin
          w_load_settle = 1'b1;
          w_state_next  = ST_SETTLE;
        end else if (w_tick) begin
          if (r_cnt == '0) begin
            w_timeout     = 1'b1;
            w_load_settle = 1'b1;
            w_state_next  = ST_SETTLE;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (w_tick) begin
          if (r_cnt == '0) begin
            w_turn_done  = 1'b1;
            w_state_next = ST_AIM;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      default: w_state_next = ST_AIM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_AIM;
      r_key_prev <= 8'h00;
      r_angle[0] <= ANGLE_DEF_P0;
      r_angle[1] <= ANGLE_DEF_P1;
      r_power[0] <= POWER_DEF;
      r_power[1] <= POWER_DEF;
      r_player   <= 1'b0;
      r_launch   <= 1'b0;
      r_launch_x <= 10'd0;
      r_launch_y <= 10'd0;
      r_timeout  <= 1'b0;
      r_turns    <= 8'd0;
      r_cnt      <= '0;
      r_seen_low <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_key_prev <= keycode;
      if (w_key_apply) begin
        case (keycode)
          KEY_A: if (r_angle[r_player] != 4'd0)
                   r_angle[r_player] <= r_angle[r_player] - 4'd1;
          KEY_D: if (r_angle[r_player] != ANGLE_MAX)
                   r_angle[r_player] <= r_angle[r_player] + 4'd1;
          KEY_W: if (r_power[r_player] != POWER_MAX)
                   r_power[r_player] <= r_power[r_player] + 3'd1;
          KEY_S: if (r_power[r_player] != 3'd0)
                   r_power[r_player] <= r_power[r_player] - 3'd1;
          KEY_SPACE: begin
            r_launch_x <= w_tank_x;
            r_launch_y <= w_tank_y - 10'(TURRET_H);
          end
          default: ;
        endcase
      end
      if (w_set_launch)      r_launch <= 1'b1;
      else if (w_clr_launch) r_launch <= 1'b0;
      if (w_load_flight)      r_cnt <= FLIGHT_LOAD;
      else if (w_load_settle) r_cnt <= SETTLE_LOAD;
      else if (w_dec)         r_cnt <= r_cnt - 1'b1;
      if (w_load_flight)                             r_seen_low <= 1'b0;
      else if (r_state == ST_FLIGHT && !exploded)    r_seen_low <= 1'b1;
      if (w_load_settle) r_timeout <= w_timeout;
      if (w_turn_done) begin
        r_player <= ~r_player;
        r_turns  <= r_turns + 8'd1;
      end
    end
  end

  assign launch       = r_launch;
  assign launchX      = r_launch_x;
  assign launchY      = r_launch_y;
  assign angle        = r_angle[r_player];
  assign power        = r_power[r_player];
  assign player       = r_player;
  assign busy         = (r_state != ST_AIM);
  assign timeout_flag = r_timeout;
  assign turn_count   = r_turns;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: aiming, launch framing, turn flow, timeout and wrap.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic [9:0] tank0_x = 10'd0, tank0_y = 10'd0, tank1_x = 10'd0, tank1_y = 10'd0;
  logic       exploded = 1'b1;
  logic       game_over = 1'b0;
  logic       launch;
  logic [9:0] launchX, launchY;
  logic [3:0] angle;
  logic [2:0] power;
  logic       player, busy, timeout_flag;
  logic [7:0] turn_count;

  int checks = 0;
  int errors = 0;
  int n_launch = 0;
  logic launch_q = 1'b0;
  int fcnt = 0;

  turn_controller dut (
    .clk(clk), .reset(reset), .frame_clk(frame_clk), .keycode(keycode),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .exploded(exploded), .game_over(game_over), .launch(launch),
    .launchX(launchX), .launchY(launchY), .angle(angle), .power(power),
    .player(player), .busy(busy), .timeout_flag(timeout_flag), .turn_count(turn_count)
  );

  always #5 clk = ~clk;

  // Frame period of 6 clk cycles, changing on the falling clk edge.
  always @(negedge clk) begin
    fcnt = (fcnt == 5) ? 0 : fcnt + 1;
    frame_clk = (fcnt < 3);
  end

  always @(negedge clk) begin
    if (launch && !launch_q) n_launch++;
    launch_q = launch;
  end

  task automatic press(input logic [7:0] k);
    @(negedge clk) keycode = k;
    @(posedge clk); #1;
  endtask

  task automatic release_key();
    @(negedge clk) keycode = 8'h00;
    @(posedge clk); #1;
  endtask

  // Press fire just after a frame tick has passed so the next frame edge is the arming tick.
  task automatic fire_aligned();
    @(posedge frame_clk);
    repeat (3) @(posedge clk);
    press(8'h2C);
  endtask

  task automatic wait_launch_pulse(input int max, output bit ok);
    int i;
    ok = 1'b0;
    for (i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (launch) break;
    end
    for (; i < max; i++) begin
      @(posedge clk); #1;
      if (!launch) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (launch !== 1'b0) begin errors++; $display("FAIL reset_launch got %0b exp 0", launch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (angle !== 4'd6 || power !== 3'd4) begin errors++; $display("FAIL reset_aim got a=%0d p=%0d exp a=6 p=4", angle, power); end
    checks++; if (player !== 1'b0 || turn_count !== 8'd0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_turn got pl=%0b tc=%0d to=%0b exp 0/0/0", player, turn_count, timeout_flag); end
    checks++; if (launchX !== 10'd0 || launchY !== 10'd0) begin errors++; $display("FAIL reset_launchxy got %0d,%0d exp 0,0", launchX, launchY); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_keys();
    press(8'h07);
    checks++; if (angle !== 4'd7) begin errors++; $display("FAIL key_latency angle got %0d exp 7", angle); end
    repeat (99) @(posedge clk);
    #1;
    checks++; if (angle !== 4'd7) begin errors++; $display("FAIL hold_d angle got %0d exp 7", angle); end
    release_key(); press(8'h07); release_key(); press(8'h07);
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL angle_max got %0d exp 8", angle); end
    release_key(); press(8'h07); release_key();
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL angle_sat got %0d exp 8", angle); end
    for (int i = 0; i < 5; i++) begin press(8'h16); release_key(); end
    checks++; if (power !== 3'd0) begin errors++; $display("FAIL power_sat got %0d exp 0", power); end
    press(8'h15); release_key();
    checks++; if (angle !== 4'd8 || power !== 3'd0) begin errors++; $display("FAIL unmapped_key got a=%0d p=%0d exp a=8 p=0", angle, power); end
  endtask

  task automatic test_launch_framing();
    tank0_x = 10'd100; tank0_y = 10'd300;
    fire_aligned();
    checks++; if (launchX !== 10'd100 || launchY !== 10'd292) begin errors++; $display("FAIL fire_latch got %0d,%0d exp 100,292", launchX, launchY); end
    checks++; if (busy !== 1'b1 || launch !== 1'b0) begin errors++; $display("FAIL fire_busy got busy=%0b launch=%0b exp 1,0", busy, launch); end
    release_key();
    @(posedge frame_clk);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (launch !== 1'b0) begin errors++; $display("FAIL launch_early got %0b exp 0", launch); end
    @(posedge clk); #1;
    checks++; if (launch !== 1'b1) begin errors++; $display("FAIL launch_rise got %0b exp 1", launch); end
    @(posedge frame_clk);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (launch !== 1'b1) begin errors++; $display("FAIL launch_hold got %0b exp 1", launch); end
    @(posedge clk); #1;
    checks++; if (launch !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL launch_fall got launch=%0b busy=%0b exp 0,1", launch, busy); end
  endtask

  task automatic test_normal_turn();
    bit ok;
    @(posedge frame_clk);
    @(negedge clk) exploded = 1'b0;
    repeat (20) @(posedge frame_clk);
    @(negedge clk) exploded = 1'b1;
    repeat (28) @(posedge frame_clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL settle_early busy got %0b exp 1", busy); end
    @(posedge frame_clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL settle_end busy got %0b exp 0", busy); end
    checks++; if (player !== 1'b1 || turn_count !== 8'd1 || timeout_flag !== 1'b0) begin errors++; $display("FAIL turn1 got pl=%0b tc=%0d to=%0b exp 1/1/0", player, turn_count, timeout_flag); end
    checks++; if (angle !== 4'd2 || power !== 3'd4) begin errors++; $display("FAIL p1_aim got a=%0d p=%0d exp 2,4", angle, power); end
    checks++; if (n_launch !== 1) begin errors++; $display("FAIL launch_count1 got %0d exp 1", n_launch); end
    ok = 1'b1;
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    tank1_x = 10'd500; tank1_y = 10'd5;
    fire_aligned();
    release_key();
    checks++; if (launchX !== 10'd500 || launchY !== 10'd1021) begin errors++; $display("FAIL p1_latch got %0d,%0d exp 500,1021", launchX, launchY); end
    wait_launch_pulse(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL p1_launch_wait got timeout exp pulse"); end
    press(8'h04); release_key();
    checks++; if (angle !== 4'd2) begin errors++; $display("FAIL flight_key angle got %0d exp 2", angle); end
    @(negedge clk) exploded = 1'b0;
    repeat (2) @(posedge frame_clk);
    @(negedge clk) exploded = 1'b1;
    repeat (2) @(posedge frame_clk);
    press(8'h2C); release_key();
    wait_idle(400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL settle_wait got timeout exp idle"); end
    checks++; if (n_launch !== 2 || player !== 1'b0 || turn_count !== 8'd2) begin errors++; $display("FAIL turn2 got n=%0d pl=%0b tc=%0d exp 2/0/2", n_launch, player, turn_count); end
    checks++; if (angle !== 4'd8 || power !== 3'd0) begin errors++; $display("FAIL p0_kept got a=%0d p=%0d exp 8,0", angle, power); end
    @(negedge clk) begin game_over = 1'b1; keycode = 8'h2C; end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || n_launch !== 2) begin errors++; $display("FAIL game_over_fire got busy=%0b n=%0d exp 0,2", busy, n_launch); end
    release_key(); press(8'h04); release_key();
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL game_over_key angle got %0d exp 8", angle); end
    @(negedge clk) game_over = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    fire_aligned();
    release_key();
    wait_launch_pulse(100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_launch_wait got timeout exp pulse"); end
    repeat (599) @(posedge frame_clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (timeout_flag !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early got to=%0b busy=%0b exp 0,1", timeout_flag, busy); end
    @(posedge frame_clk);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (timeout_flag !== 1'b1) begin errors++; $display("FAIL to_flag got %0b exp 1", timeout_flag); end
    wait_idle(400, ok);
    checks++; if (!ok || player !== 1'b1 || turn_count !== 8'd3) begin errors++; $display("FAIL to_turn got ok=%0b pl=%0b tc=%0d exp 1/1/3", ok, player, turn_count); end
  endtask

  task automatic test_reset_midflight();
    // Fire lands on the tick cycle: that tick must not arm the launch.
    @(posedge frame_clk);
    repeat (2) @(posedge clk);
    press(8'h2C);
    checks++; if (busy !== 1'b1 || launch !== 1'b0) begin errors++; $display("FAIL fire_tick got busy=%0b launch=%0b exp 1,0", busy, launch); end
    release_key();
    @(posedge frame_clk);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (launch !== 1'b0) begin errors++; $display("FAIL fire_tick_early got %0b exp 0", launch); end
    @(posedge clk); #1;
    checks++; if (launch !== 1'b1) begin errors++; $display("FAIL fire_tick_launch got %0b exp 1", launch); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (launch !== 1'b0 || busy !== 1'b0 || turn_count !== 8'd0 || launchX !== 10'd0) begin errors++; $display("FAIL mid_reset got l=%0b b=%0b tc=%0d lx=%0d exp 0/0/0/0", launch, busy, turn_count, launchX); end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_wrap();
    bit ok;
    for (int t = 0; t < 256; t++) begin
      press(8'h2C); release_key();
      wait_launch_pulse(100, ok);
      if (!ok) begin checks++; errors++; $display("FAIL wrap_launch turn %0d got timeout exp pulse", t); break; end
      @(negedge clk) exploded = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) exploded = 1'b1;
      wait_idle(400, ok);
      if (!ok) begin checks++; errors++; $display("FAIL wrap_idle turn %0d got timeout exp idle", t); break; end
      if (t == 254) begin
        checks++; if (turn_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", turn_count); end
      end
    end
    checks++; if (turn_count !== 8'd0 || player !== 1'b0) begin errors++; $display("FAIL wrap_zero got tc=%0d pl=%0b exp 0,0", turn_count, player); end
  endtask

  initial begin
    test_reset();
    test_keys();
    test_launch_framing();
    test_normal_turn();
    test_ignored_inputs();
    test_timeout();
    test_reset_midflight();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
